// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller <-> multicycle datapath signal bundle
// master = control sequencer, slave = datapath side.
interface mips_multicycle_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCEn;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;
    logic       Fault;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Zero, MemReady,
        output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, ALUControl, Fault, State
    );

    modport slave (
        output Op, Funct, Zero, MemReady,
        input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, ALUControl, Fault, State
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore control sequencer for the multicycle MIPS datapath
// Optional performance counters enabled by defining MULTICYCLE_PERF_EN.
module mips_multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    mips_multicycle_ctrl_if.master bus
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0] CycleCount,
    output logic [31:0] InstrRetired
`endif
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [2:0] funct_alu;
    logic       funct_ok;
    logic       mem_wait;
    logic       timeout;
    logic       pc_write;
    logic       branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (bus.Funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            6'b100111: funct_alu = 3'b100;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // A stall that reaches the limit traps, but a completing access in that cycle wins.
    assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign timeout  = mem_wait && !bus.MemReady && (wait_q == 8'(WAIT_LIMIT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000000:            state_d = S_EXECUTE;
                    6'b000100:            state_d = S_BRANCH;
                    6'b001000:            state_d = S_ADDIEX;
                    6'b000010:            state_d = S_JUMP;
                    default:              state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (bus.Op == 6'b100011) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
            S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
            S_EXECUTE:  state_d = funct_ok ? S_ALUWB : S_TRAP;
            S_ADDIEX:   state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            default:    state_d = S_TRAP;
        endcase
        if (timeout) state_d = S_TRAP;
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q)             wait_d = 8'd0;
        else if (mem_wait && !bus.MemReady) wait_d = wait_q + 8'd1;
    end

    always_comb begin
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.PCSrc      = 2'b00;
        bus.ALUControl = 3'b010;
        pc_write       = 1'b0;
        branch         = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.MemReady;
                pc_write    = bus.MemReady;
            end
            S_DECODE:   bus.ALUSrcB = 2'b11;
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = funct_alu;
            end
            S_ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = 3'b110;
                bus.PCSrc      = 2'b01;
                branch         = 1'b1;
            end
            S_ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            S_ADDIWB:   bus.RegWrite = 1'b1;
            S_JUMP: begin
                bus.PCSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCEn  = pc_write | (branch & bus.Zero);
    assign bus.Fault = (state_q == S_TRAP);
    assign bus.State = state_q;

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_q, retired_q;
    logic        retire;

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) || (state_q == S_ALUWB) ||
                     (state_q == S_BRANCH) || (state_q == S_ADDIWB) || (state_q == S_JUMP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            if (state_q != S_TRAP) cycle_q   <= cycle_q + 32'd1;
            if (retire)            retired_q <= retired_q + 32'd1;
        end
    end

    assign CycleCount   = cycle_q;
    assign InstrRetired = retired_q;
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
    localparam int WL = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus();
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    mips_multicycle_ctrl #(.WAIT_LIMIT(WL)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
`ifdef MULTICYCLE_PERF_EN
        ,
        .CycleCount(cyc_cnt),
        .InstrRetired(ret_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] qs[$];
    logic       qr[$];
    logic [3:0] exp_state;
    bit         chk_en = 0;
    logic [10:0] tbl [16];

    function automatic bit funct_legal(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        logic [2:0] r;
        r = 3'b010;
        if (f == 6'b100010) r = 3'b110;
        if (f == 6'b100100) r = 3'b000;
        if (f == 6'b100101) r = 3'b001;
        if (f == 6'b101010) r = 3'b111;
        if (f == 6'b100111) r = 3'b100;
        return r;
    endfunction

    // {IorD,MemRead,MemWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,IRWrite,PCEn,ALUControl,Fault}
    function automatic logic [16:0] expv(input logic [3:0] st, input logic rdy,
                                         input logic [5:0] f, input logic z);
        logic       irw, pcen;
        logic [2:0] alu;
        irw  = (st == 4'd0) && rdy;
        pcen = irw || (st == 4'd11) || ((st == 4'd8) && z);
        alu  = (st == 4'd6) ? alu_of(f) : ((st == 4'd8) ? 3'b110 : 3'b010);
        return {tbl[st], irw, pcen, alu, (st == 4'd15)};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [16:0] act, ex;
            act = {bus.IorD, bus.MemRead, bus.MemWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                   bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.IRWrite, bus.PCEn, bus.ALUControl, bus.Fault};
            ex  = expv(exp_state, bus.MemReady, bus.Funct, bus.Zero);
            checks++;
            if (bus.State !== exp_state) begin
                errors++;
                $display("FAIL state @%0t: got %0d expected %0d", $time, bus.State, exp_state);
            end
            checks++;
            if (act !== ex) begin
                errors++;
                $display("FAIL outputs @%0t state %0d: got %b expected %b", $time, exp_state, act, ex);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic push(input logic [3:0] s, input logic r);
        qs.push_back(s);
        qr.push_back(r);
    endtask

    task automatic push_trap(input int n);
        repeat (n) push(4'd15, 1'b0);
    endtask

    // Expected state sequence of one instruction, from fetch until back at FETCH or in TRAP.
    task automatic build(input logic [5:0] op, input logic [5:0] f, input int fstall,
                         input int mstall, input int trap_len);
        qs.delete();
        qr.delete();
        if (fstall >= WL) begin
            repeat (WL) push(4'd0, 1'b0);
            push_trap(trap_len);
            return;
        end
        repeat (fstall) push(4'd0, 1'b0);
        push(4'd0, 1'b1);
        push(4'd1, 1'b1);
        case (op)
            6'b100011, 6'b101011: begin
                push(4'd2, 1'b1);
                if (mstall >= WL) begin
                    repeat (WL) push((op == 6'b100011) ? 4'd3 : 4'd5, 1'b0);
                    push_trap(trap_len);
                    return;
                end
                repeat (mstall) push((op == 6'b100011) ? 4'd3 : 4'd5, 1'b0);
                push((op == 6'b100011) ? 4'd3 : 4'd5, 1'b1);
                if (op == 6'b100011) push(4'd4, 1'b1);
            end
            6'b000000: begin
                push(4'd6, 1'b1);
                if (funct_legal(f)) push(4'd7, 1'b1);
                else push_trap(trap_len);
            end
            6'b000100: push(4'd8, 1'b1);
            6'b001000: begin
                push(4'd9, 1'b1);
                push(4'd10, 1'b1);
            end
            6'b000010: push(4'd11, 1'b1);
            default:   push_trap(trap_len);
        endcase
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] f, input logic z, input int n);
        bus.Op    = op;
        bus.Funct = f;
        bus.Zero  = z;
        for (int i = 0; i < qs.size() && i < n; i++) begin
            exp_state     = qs[i];
            bus.MemReady  = qr[i];
            chk_en        = 1;
            @(posedge clk);
            #1;
        end
        chk_en = 0;
    endtask

    task automatic do_reset();
        chk_en = 0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", 32'(bus.State), 32'd0);
        check("reset_fault", 32'(bus.Fault), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = 11'b0_1_0_0_0_0_0_01_00;
        tbl[1]  = 11'b0_0_0_0_0_0_0_11_00;
        tbl[2]  = 11'b0_0_0_0_0_0_1_10_00;
        tbl[3]  = 11'b1_1_0_0_0_0_0_00_00;
        tbl[4]  = 11'b0_0_0_0_1_1_0_00_00;
        tbl[5]  = 11'b1_0_1_0_0_0_0_00_00;
        tbl[6]  = 11'b0_0_0_0_0_0_1_00_00;
        tbl[7]  = 11'b0_0_0_1_0_1_0_00_00;
        tbl[8]  = 11'b0_0_0_0_0_0_1_00_01;
        tbl[9]  = 11'b0_0_0_0_0_0_1_10_00;
        tbl[10] = 11'b0_0_0_0_0_1_0_00_00;
        tbl[11] = 11'b0_0_0_0_0_0_0_00_10;
        tbl[12] = 11'd0;
        tbl[13] = 11'd0;
        tbl[14] = 11'd0;
        tbl[15] = 11'd0;

        reset        = 1'b1;
        bus.Op       = 6'd0;
        bus.Funct    = 6'd0;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b0;
        @(posedge clk);
        #1;
        check("reset_memread", 32'(bus.MemRead), 32'd1);
        check("reset_state0", 32'(bus.State), 32'd0);
        reset = 1'b0;

        build(6'b000000, 6'b100000, 0, 0, 0);
        check("add_latency", qs.size(), 32'd4);
        run(6'b000000, 6'b100000, 1'b0, 100);

        foreach (qs[i]) ;
        build(6'b100011, 6'd0, 0, 3, 0);
        check("lw_stall_latency", qs.size(), 32'd8);
        run(6'b100011, 6'd0, 1'b0, 100);

        build(6'b101011, 6'd0, 0, 0, 0);
        check("sw_latency", qs.size(), 32'd4);
        run(6'b101011, 6'd0, 1'b0, 100);

        build(6'b000100, 6'd0, 0, 0, 0);
        check("beq_latency", qs.size(), 32'd3);
        run(6'b000100, 6'd0, 1'b1, 100);
        run(6'b000100, 6'd0, 1'b0, 100);

        build(6'b001000, 6'd0, 0, 0, 0);
        check("addi_latency", qs.size(), 32'd4);
        run(6'b001000, 6'd0, 1'b0, 100);

        build(6'b000010, 6'd0, 0, 0, 0);
        check("j_latency", qs.size(), 32'd3);
        run(6'b000010, 6'd0, 1'b0, 100);

        for (int k = 0; k < 6; k++) begin
            logic [5:0] fl [6];
            fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
            build(6'b000000, fl[k], 1, 0, 0);
            run(6'b000000, fl[k], 1'b0, 100);
        end

        build(6'b111111, 6'd0, 0, 0, 20);
        run(6'b111111, 6'd0, 1'b0, 100);
        check("illegal_op_fault", 32'(bus.Fault), 32'd1);
        check("illegal_op_state", 32'(bus.State), 32'd15);
        do_reset();

        build(6'b000000, 6'b000001, 0, 0, 5);
        run(6'b000000, 6'b000001, 1'b0, 100);
        check("illegal_funct_fault", 32'(bus.Fault), 32'd1);
        do_reset();

        build(6'b000000, 6'b100000, WL, 0, 5);
        run(6'b000000, 6'b100000, 1'b0, 100);
        check("fetch_timeout_fault", 32'(bus.Fault), 32'd1);
        do_reset();

        build(6'b000000, 6'b100000, WL - 1, 0, 0);
        run(6'b000000, 6'b100000, 1'b0, 100);
        check("limit_ready_no_fault", 32'(bus.Fault), 32'd0);

        build(6'b100011, 6'd0, 0, WL, 3);
        run(6'b100011, 6'd0, 1'b0, 100);
        check("memread_timeout_fault", 32'(bus.Fault), 32'd1);
        do_reset();

        build(6'b101011, 6'd0, 0, 3, 0);
        run(6'b101011, 6'd0, 1'b0, 4);
        check("sw_in_memwrite", 32'(bus.MemWrite), 32'd1);
        bus.MemReady = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_memwrite", 32'(bus.MemWrite), 32'd0);
        check("async_reset_state", 32'(bus.State), 32'd0);
`ifdef MULTICYCLE_PERF_EN
        check("async_reset_cycles", cyc_cnt, 32'd0);
        check("async_reset_retired", ret_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        build(6'b000000, 6'b101010, 0, 0, 0);
        run(6'b000000, 6'b101010, 1'b0, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
